// File: rtl/rsa_modexp.sv
// Modular exponentiation result = msg^exp mod n. It scans the exponent left to right
// with square-and-multiply on a bit-serial interleaved modular multiplier.
module rsa_modexp #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] msg,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] result,
    output logic             finish,
    output logic             err,
    output logic             busy,
    output logic [CNT_W-1:0] cycles
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_SQR   = 3'd2;
    localparam logic [2:0] S_MUL   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q,  state_d;
    logic [WIDTH-1:0] msg_q,    msg_d;
    logic [WIDTH-1:0] exp_q,    exp_d;
    logic [WIDTH-1:0] n_q,      n_d;
    logic [WIDTH-1:0] r_q,      r_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [IW-1:0]    bit_q,    bit_d;
    logic [IW-1:0]    k_q,      k_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             finish_q, finish_d;
    logic             err_q,    err_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    // One step of the interleaved multiplier: acc = (2*acc + b[i]*r) mod n.
    // Both operands are below n, so each partial fits in WIDTH+1 bits and one
    // conditional subtract is enough after the doubling and after the add.
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH:0]   n_ext;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   dbl_red;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sum_red;
    logic [WIDTH-1:0] step_res;

    always_comb begin
        mul_b    = (state_q == S_MUL) ? msg_q : r_q;
        n_ext    = {1'b0, n_q};
        dbl      = {acc_q, 1'b0};
        dbl_red  = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
        sum      = dbl_red + (mul_b[bit_q] ? {1'b0, r_q} : {(WIDTH+1){1'b0}});
        sum_red  = (sum >= n_ext) ? (sum - n_ext) : sum;
        step_res = sum_red[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        exp_d    = exp_q;
        n_d      = n_q;
        r_d      = r_q;
        acc_d    = acc_q;
        bit_d    = bit_q;
        k_d      = k_q;
        result_d = result_q;
        finish_d = 1'b0;
        err_d    = err_q;
        cycles_d = cycles_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    msg_d    = msg;
                    exp_d    = exp;
                    n_d      = n;
                    r_d      = WIDTH'(1);
                    k_d      = IW'(WIDTH - 1);
                    cycles_d = '0;
                    err_d    = 1'b0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                cycles_d = cycles_q + CNT_W'(1);
                if ((n_q < WIDTH'(2)) || (msg_q >= n_q)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    acc_d   = '0;
                    bit_d   = IW'(WIDTH - 1);
                    state_d = S_SQR;
                end
            end
            S_SQR, S_MUL: begin
                cycles_d = cycles_q + CNT_W'(1);
                acc_d    = step_res;
                if (bit_q == '0) begin
                    r_d   = step_res;
                    acc_d = '0;
                    bit_d = IW'(WIDTH - 1);
                    if ((state_q == S_SQR) && exp_q[k_q]) begin
                        state_d = S_MUL;
                    end else if (k_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q - IW'(1);
                        state_d = S_SQR;
                    end
                end else begin
                    bit_d = bit_q - IW'(1);
                end
            end
            S_DONE: begin
                cycles_d = cycles_q + CNT_W'(1);
                finish_d = 1'b1;
                result_d = err_q ? '0 : r_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            msg_q    <= '0;
            exp_q    <= '0;
            n_q      <= '0;
            r_q      <= '0;
            acc_q    <= '0;
            bit_q    <= '0;
            k_q      <= '0;
            result_q <= '0;
            finish_q <= 1'b0;
            err_q    <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            exp_q    <= exp_d;
            n_q      <= n_d;
            r_q      <= r_d;
            acc_q    <= acc_d;
            bit_q    <= bit_d;
            k_q      <= k_d;
            result_q <= result_d;
            finish_q <= finish_d;
            err_q    <= err_d;
            cycles_q <= cycles_d;
        end
    end

    // err is only meaningful alongside finish but is held like result.
    assign result = result_q;
    assign finish = finish_q;
    assign err    = err_q;
    assign busy   = (state_q != S_IDLE);
    assign cycles = cycles_q;

endmodule
